// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display blocks.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    localparam int PHASES = 16;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Digit code table, entry n at bits [7n+6:7n].
    localparam logic [69:0] SEG_TBL = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [1:0] {
        PH_DEAD,
        PH_DRIVE,
        PH_OFF
    } phase_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble to active-low 7-segment code.
// Nibbles A-F show a dash.
module bcd_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Table lookup for valid digits, dash otherwise.
    always_comb begin
        seg = SEG_DASH;
        if (nib <= 4'd9) begin
            seg = SEG_TBL[7 * nib +: 7];
        end
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Scan scheduler for the shared 8-digit common-anode display.
// Dead-time, PWM, leading-zero blanking, tear-free updates.
module seg_scan_scheduler
    import seg_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SLOT_HZ  = 8_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_data,
    input  logic [7:0]  upd_dp,
    input  logic [7:0]  digit_en,
    input  logic [3:0]  brightness,
    input  logic        lz_blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        frame_tick
);

    localparam int SLOT_CYC = CLK_FREQ / SLOT_HZ;
    localparam int PH_CYC   = SLOT_CYC / PHASES;
    localparam int CW       = $clog2(SLOT_CYC);
    localparam int SW       = (PH_CYC > 1) ? $clog2(PH_CYC) : 1;

    if (SLOT_CYC < 32 || SLOT_CYC % 16 != 0) begin : g_bad_cfg
        $error("seg_scan_scheduler: SLOT_CYC=%0d invalid", SLOT_CYC);
    end

    logic [CW-1:0] cnt;
    logic [SW-1:0] sub;
    logic [3:0]    phase;
    logic [2:0]    idx;
    logic [7:0]    en_r;
    logic [3:0]    br_r;
    logic          lz_r;
    logic [31:0]   act_data;
    logic [7:0]    act_dp;
    logic [31:0]   pend_data;
    logic [7:0]    pend_dp;
    logic          pend_full;
    phase_e        st;
    phase_e        st_nx;

    logic          slot_end;
    logic          sub_end;
    logic          boundary;
    logic          accept;
    logic [2:0]    nxt_idx;
    logic [2:0]    low_idx;
    logic [2:0]    j;
    logic          found;
    logic          wrap;
    logic [3:0]    nib;
    logic          dp_bit;
    logic          blank;
    logic [6:0]    dec_seg;

    assign slot_end  = (cnt == CW'(SLOT_CYC - 1));
    assign sub_end   = (sub == SW'(PH_CYC - 1));
    assign boundary  = slot_end && ((en_r == 8'h00) || wrap);
    assign upd_ready = !pend_full;
    assign accept    = upd_valid && !pend_full;

    // Next enabled digit above idx, wrapping through 7 back to 0.
    always_comb begin
        nxt_idx = idx;
        found   = 1'b0;
        j       = idx;
        for (int k = 1; k <= 8; k++) begin
            j = idx + 3'(k);
            if (!found && en_r[j]) begin
                nxt_idx = j;
                found   = 1'b1;
            end
        end
        wrap = found && (nxt_idx <= idx);
    end

    // Lowest enabled digit of the incoming mask starts each frame.
    always_comb begin
        low_idx = idx;
        for (int i = 7; i >= 0; i--) begin
            if (digit_en[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    // Select the active digit and decide leading-zero blanking.
    always_comb begin
        nib    = act_data[{idx, 2'b00} +: 4];
        dp_bit = act_dp[idx];
        blank  = lz_r && (idx != 3'd0);
        for (int i = 0; i < 8; i++) begin
            if (i >= int'(idx) && act_data[4*i +: 4] != 4'd0) begin
                blank = 1'b0;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    // Phase classification of the current cnt position.
    always_comb begin
        if (phase == 4'd0) begin
            st_nx = PH_DEAD;
        end else if (phase <= br_r && en_r[idx]) begin
            st_nx = PH_DRIVE;
        end else begin
            st_nx = PH_OFF;
        end
    end

    // Slot counter with a sub-counter producing the 16 phases.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt   <= '0;
            sub   <= '0;
            phase <= 4'd0;
        end else if (slot_end) begin
            cnt   <= '0;
            sub   <= '0;
            phase <= 4'd0;
        end else begin
            cnt <= cnt + 1'b1;
            if (sub_end) begin
                sub   <= '0;
                phase <= phase + 4'd1;
            end else begin
                sub <= sub + 1'b1;
            end
        end
    end

    // Digit advance, frame-boundary config/content swap, update port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx        <= 3'd0;
            en_r       <= 8'h00;
            br_r       <= 4'd0;
            lz_r       <= 1'b0;
            act_data   <= 32'h0;
            act_dp     <= 8'h00;
            pend_data  <= 32'h0;
            pend_dp    <= 8'h00;
            pend_full  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (boundary) begin
                en_r <= digit_en;
                br_r <= brightness;
                lz_r <= lz_blank;
                idx  <= (digit_en != 8'h00) ? low_idx : idx;
            end else if (slot_end) begin
                idx <= nxt_idx;
            end
            if (boundary && pend_full) begin
                act_data  <= pend_data;
                act_dp    <= pend_dp;
                pend_full <= 1'b0;
            end else if (accept) begin
                pend_data <= upd_data;
                pend_dp   <= upd_dp;
                pend_full <= 1'b1;
            end
        end
    end

    // Phase FSM with registered anode/segment outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st  <= PH_DEAD;
            an  <= 8'hFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            st <= st_nx;
            unique case (st_nx)
                PH_DRIVE: begin
                    an  <= ~(8'b1 << idx);
                    seg <= blank ? SEG_BLANK : dec_seg;
                    dp  <= ~dp_bit;
                end
                default: begin
                    an  <= 8'hFF;
                    seg <= SEG_BLANK;
                    dp  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler, SLOT_CYC=32.
// Vector table per frame plus handshake and reset sequences.
module tb_seg_scan_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_data;
    logic [7:0]  upd_dp;
    logic [7:0]  digit_en;
    logic [3:0]  brightness;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seg_scan_scheduler #(
        .CLK_FREQ (3200),
        .SLOT_HZ  (100)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_data   (upd_data),
        .upd_dp     (upd_dp),
        .digit_en   (digit_en),
        .brightness (brightness),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    typedef struct {
        logic [7:0]       en;
        logic [3:0]       br;
        logic             lz;
        logic [31:0]      data;
        logic [7:0]       dpm;
        int               frame_len;
        int               on_cyc;
        logic [7:0][6:0]  segx;
        logic [7:0]       dpx;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    task automatic wait_tick(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        if (!seen) timeout_fail(name);
    endtask

    task automatic wait_an(input logic [7:0] want, input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            if (an === want) seen = 1'b1;
        end
        if (!seen) timeout_fail(name);
    endtask

    task automatic push(input logic [31:0] d, input logic [7:0] m);
        upd_valid = 1'b1;
        upd_data  = d;
        upd_dp    = m;
        @(negedge clk);
        upd_valid = 1'b0;
        check("push accepted", {31'd0, upd_ready}, 32'd0);
    endtask

    task automatic measure(input vec_t v, input int vi);
        int ord[8];
        int nd = 0;
        int low_cnt[8];
        int first_off[8];
        int bad[8];
        logic [15:0] bad_val[8];
        int tick_at = -1;
        for (int d = 0; d < 8; d++) begin
            low_cnt[d]   = 0;
            first_off[d] = -1;
            bad[d]       = 0;
            bad_val[d]   = '0;
            if (v.en[d]) begin
                ord[nd] = d;
                nd++;
            end
        end
        for (int k = 1; k <= v.frame_len; k++) begin
            int s;
            int off;
            @(negedge clk);
            s   = (k - 1) / 32;
            off = (k - 1) % 32;
            if (frame_tick === 1'b1 && tick_at < 0) tick_at = k;
            if (s < 8 && an !== 8'hFF) begin
                logic [7:0] ea;
                int d;
                d  = (s < nd) ? ord[s] : 0;
                ea = ~(8'b1 << d);
                low_cnt[s]++;
                if (first_off[s] < 0) first_off[s] = off;
                if ({an, seg, dp} !== {ea, v.segx[d], v.dpx[d]}) begin
                    if (bad[s] == 0) bad_val[s] = {an, seg, dp};
                    bad[s]++;
                end
            end
        end
        check($sformatf("v%0d frame_tick period", vi), tick_at, v.frame_len);
        for (int s = 0; s < nd; s++) begin
            int d;
            d = ord[s];
            check($sformatf("v%0d slot%0d low cycles", vi, s),
                  low_cnt[s], v.on_cyc);
            if (v.on_cyc > 0) begin
                check($sformatf("v%0d slot%0d drive start", vi, s),
                      first_off[s], 2);
                check($sformatf("v%0d slot%0d {an,seg,dp}", vi, s),
                      {16'd0, (bad[s] == 0) ? {~(8'b1 << d), v.segx[d],
                       v.dpx[d]} : bad_val[s]},
                      {16'd0, ~(8'b1 << d), v.segx[d], v.dpx[d]});
            end
        end
    endtask

    initial begin
        int n;
        int lows;
        bit seen;

        vecs[0] = '{8'h0F, 4'd15, 1'b0, 32'h0000_1234, 8'h00, 128, 30,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F,
                     7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                    8'hFF};
        vecs[1] = '{8'hFF, 4'd15, 1'b1, 32'h0000_0050, 8'h00, 256, 30,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F,
                     7'h7F, 7'h7F, 7'b0010010, 7'b1000000},
                    8'hFF};
        vecs[2] = '{8'hFF, 4'd4, 1'b1, 32'h0000_0050, 8'h04, 256, 8,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F,
                     7'h7F, 7'h7F, 7'b0010010, 7'b1000000},
                    8'hFB};
        vecs[3] = '{8'h0F, 4'd0, 1'b0, 32'h0000_1234, 8'h00, 128, 0,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F,
                     7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                    8'hFF};
        vecs[4] = '{8'h81, 4'd15, 1'b0, 32'hB000_0009, 8'h80, 64, 30,
                    {7'b0111111, 7'h7F, 7'h7F, 7'h7F,
                     7'h7F, 7'h7F, 7'h7F, 7'b0010000},
                    8'h7F};
        vecs[5] = '{8'h01, 4'd2, 1'b1, 32'h0000_0000, 8'h00, 32, 4,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F,
                     7'h7F, 7'h7F, 7'h7F, 7'b1000000},
                    8'hFF};
        vecs[6] = '{8'h24, 4'd7, 1'b0, 32'h0050_0A00, 8'h00, 64, 14,
                    {7'h7F, 7'h7F, 7'b0010010, 7'h7F,
                     7'h7F, 7'b0111111, 7'h7F, 7'h7F},
                    8'hFF};

        reset_n    = 1'b0;
        upd_valid  = 1'b0;
        upd_data   = 32'h0;
        upd_dp     = 8'h00;
        digit_en   = 8'h00;
        brightness = 4'd0;
        lz_blank   = 1'b0;

        repeat (3) @(negedge clk);
        check("reset an", {24'd0, an}, 32'hFF);
        check("reset seg", {25'd0, seg}, 32'h7F);
        check("reset dp", {31'd0, dp}, 32'd1);
        check("reset frame_tick", {31'd0, frame_tick}, 32'd0);
        check("reset upd_ready", {31'd0, upd_ready}, 32'd1);

        reset_n = 1'b1;
        n    = 0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            n++;
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        check("first frame_tick latency", n, 32);

        for (int i = 0; i < 7; i++) begin
            digit_en   = vecs[i].en;
            brightness = vecs[i].br;
            lz_blank   = vecs[i].lz;
            push(vecs[i].data, vecs[i].dpm);
            wait_tick($sformatf("v%0d boundary", i));
            measure(vecs[i], i);
        end

        digit_en   = 8'h0F;
        brightness = 4'd15;
        lz_blank   = 1'b0;
        wait_tick("hs cfg boundary");
        repeat (3) @(negedge clk);
        upd_valid = 1'b1;
        upd_data  = 32'h0000_0011;
        upd_dp    = 8'h00;
        @(negedge clk);
        check("hs first accept", {31'd0, upd_ready}, 32'd0);
        upd_data = 32'h0000_0022;
        seen = 1'b0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            if (upd_ready === 1'b1) seen = 1'b1;
        end
        if (!seen) timeout_fail("hs ready return");
        check("hs ready at boundary", {31'd0, frame_tick}, 32'd1);
        @(negedge clk);
        check("hs second accept", {31'd0, upd_ready}, 32'd0);
        upd_valid = 1'b0;
        wait_an(8'hFE, "hs frame A digit0");
        check("hs frame A digit0 seg", {25'd0, seg}, {25'd0, 7'b1111001});
        wait_tick("hs frame B boundary");
        wait_an(8'hFE, "hs frame B digit0");
        check("hs frame B digit0 seg", {25'd0, seg}, {25'd0, 7'b0100100});

        wait_an(8'hFD, "drive before reset");
        reset_n = 1'b0;
        @(negedge clk);
        check("mid reset an", {24'd0, an}, 32'hFF);
        check("mid reset seg", {25'd0, seg}, 32'h7F);
        check("mid reset dp", {31'd0, dp}, 32'd1);
        check("mid reset upd_ready", {31'd0, upd_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        n    = 0;
        lows = 0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            n++;
            if (an !== 8'hFF) lows++;
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        check("post reset tick latency", n, 32);
        check("post reset dark frame", lows, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
